// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one external address/data bus between NREQ requesters. Requester 0
//   is the CPU and, with CPU_PRIO=1, wins whenever it requests; the remaining
//   requesters are served round-robin. Each grant covers one read or write with
//   a fixed access time (WAIT_CYCLES+1 cycles), followed by a single turnaround
//   cycle before the next arbitration.
//
//   Ports:
//     clk        clock, all state on the rising edge
//     reset      asynchronous active-high reset
//     req        per-requester level request, held until done
//     we_in      per-requester direction (1 = write)
//     addr_in    flat per-requester addresses, requester i at [i*AW +: AW]
//     wdata_in   flat per-requester write data, requester i at [i*DW +: DW]
//     gnt        one-hot grant, high for the whole transaction
//     done       one-cycle completion pulse to the granted requester
//     rdata      captured read data, held until the next read completes
//     bus_addr   external address
//     bus_wdata  external write data
//     bus_we     external write strobe
//     bus_oe     data bus drive enable (write access only)
//     bus_rdata  external read data
//     busy       high whenever a transaction is in progress
module bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int CPU_PRIO    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we_in,
  input  logic [NREQ*AW-1:0]   addr_in,
  input  logic [NREQ*DW-1:0]   wdata_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        bus_addr,
  output logic [DW-1:0]        bus_wdata,
  output logic                 bus_we,
  output logic                 bus_oe,
  input  logic [DW-1:0]        bus_rdata,
  output logic                 busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t              state_reg, state_next;
  logic [LW-1:0]       last_reg;
  logic [3:0]          cnt_reg;
  logic                we_reg;
  logic [NREQ-1:0]     gnt_reg, done_reg;
  logic [AW-1:0]       addr_reg;
  logic [DW-1:0]       wdata_reg, rdata_reg;
  logic                bus_we_reg, bus_oe_reg;

  logic [LW-1:0]       win_idx;
  logic                win_found;
  logic                win_prio;
  int                  scan_idx;

  // Winner selection. The CPU override leaves the round-robin pointer alone so
  // the other masters keep their place in the rotation.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    win_prio  = 1'b0;
    scan_idx  = 0;
    if (CPU_PRIO != 0 && req[0]) begin
      win_found = 1'b1;
      win_prio  = 1'b1;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        scan_idx = (int'(last_reg) + off) % NREQ;
        if (!win_found && req[scan_idx] && !(CPU_PRIO != 0 && scan_idx == 0)) begin
          win_idx   = LW'(scan_idx);
          win_found = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found) state_next = ACCESS;
      ACCESS:  if (cnt_reg == 4'd0) state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latches the winner's request at the grant edge so
  // later changes on the requester side cannot disturb the bus cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_reg   <= LW'(NREQ - 1);
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      gnt_reg    <= '0;
      done_reg   <= '0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      bus_we_reg <= 1'b0;
      bus_oe_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            if (!win_prio) last_reg <= win_idx;
            gnt_reg    <= NREQ'(1) << win_idx;
            addr_reg   <= addr_in[win_idx*AW +: AW];
            wdata_reg  <= wdata_in[win_idx*DW +: DW];
            we_reg     <= we_in[win_idx];
            bus_we_reg <= we_in[win_idx];
            bus_oe_reg <= we_in[win_idx];
            cnt_reg    <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            if (!we_reg) rdata_reg <= bus_rdata;
            done_reg   <= gnt_reg;
            bus_we_reg <= 1'b0;
            bus_oe_reg <= 1'b0;
          end
        end
        RELEASE: begin
          done_reg <= '0;
          gnt_reg  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy      = (state_reg != IDLE);
    gnt       = gnt_reg;
    done      = done_reg;
    rdata     = rdata_reg;
    bus_addr  = addr_reg;
    bus_wdata = wdata_reg;
    bus_we    = bus_we_reg;
    bus_oe    = bus_oe_reg;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req, req_rr, we_in;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] wdata_in;
  logic [DW-1:0]     bus_rdata;

  logic [NREQ-1:0]   gnt, done, gnt_rr, done_rr;
  logic [DW-1:0]     rdata, bus_wdata, rdata_rr, bus_wdata_rr;
  logic [AW-1:0]     bus_addr, bus_addr_rr;
  logic              bus_we, bus_oe, busy, bus_we_rr, bus_oe_rr, busy_rr;

  typedef struct {
    int         idx;
    logic       we;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  sb_t q[$];
  sb_t q_rr[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_CYCLES(1), .CPU_PRIO(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we_in(we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt), .done(done), .rdata(rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_oe(bus_oe),
    .bus_rdata(bus_rdata), .busy(busy)
  );

  bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_CYCLES(1), .CPU_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset), .req(req_rr), .we_in(we_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .gnt(gnt_rr), .done(done_rr), .rdata(rdata_rr),
    .bus_addr(bus_addr_rr), .bus_wdata(bus_wdata_rr), .bus_we(bus_we_rr), .bus_oe(bus_oe_rr),
    .bus_rdata(bus_rdata), .busy(busy_rr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples 1 time unit after the edge and checks bus invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("onehot0_gnt",    32'($onehot0(gnt)), 1);
    chk("oe_implies_we",  32'(!bus_oe || bus_we), 1);
    chk("oe_only_access", 32'(!bus_oe || (busy && done == 0)), 1);
    chk("done_with_gnt",  32'((done & ~gnt) == 0), 1);
    chk("rr_onehot0_gnt", 32'($onehot0(gnt_rr)), 1);
    chk("rr_oe_implies_we", 32'(!bus_oe_rr || bus_we_rr), 1);
    chk("rr_done_with_gnt", 32'((done_rr & ~gnt_rr) == 0), 1);
  endtask

  // Waits (bounded) for the next done pulse and checks it against the
  // scoreboard; optionally checks the round-robin instance in the same cycle.
  task automatic wait_done(input bit with_rr, output int n);
    sb_t  e;
    logic saw_we;
    n = 0;
    saw_we = 1'b0;
    do begin
      tick();
      n++;
      if (bus_we) saw_we = 1'b1;
    end while (done == 0 && n < 40);
    chk("done_timeout", 32'(done != 0), 1);
    chk("sb_nonempty", 32'(q.size() != 0), 1);
    if (done != 0 && q.size() != 0) begin
      e = q.pop_front();
      $display("txn: req=%0d we=%0d addr=0x%04h gnt=%b done=%b rdata=0x%04h wdata=0x%04h",
               e.idx, e.we, bus_addr, gnt, done, rdata, bus_wdata);
      chk("done_vec",    32'(done), 32'(1) << e.idx);
      chk("gnt_at_done", 32'(gnt),  32'(1) << e.idx);
      chk("addr",        32'(bus_addr), 32'(e.addr));
      chk("we_seen",     32'(saw_we), 32'(e.we));
      chk("we_off_release", 32'(bus_we), 0);
      if (e.we) chk("wdata", 32'(bus_wdata), 32'(e.data));
      else      chk("rdata", 32'(rdata), 32'(e.data));
    end
    if (with_rr) begin
      chk("rr_sb_nonempty", 32'(q_rr.size() != 0), 1);
      if (q_rr.size() != 0) begin
        e = q_rr.pop_front();
        $display("txn_rr: req=%0d addr=0x%04h gnt=%b done=%b rdata=0x%04h",
                 e.idx, bus_addr_rr, gnt_rr, done_rr, rdata_rr);
        chk("rr_done_vec", 32'(done_rr), 32'(1) << e.idx);
        chk("rr_addr",     32'(bus_addr_rr), 32'(e.addr));
        chk("rr_rdata",    32'(rdata_rr), 32'(e.data));
      end
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == 0 && n < 40);
    chk("gnt_timeout", 32'(gnt != 0), 1);
  endtask

  function automatic sb_t mk(input int idx, input logic we, input logic [15:0] a, input logic [15:0] d);
    sb_t e;
    e.idx = idx; e.we = we; e.addr = a; e.data = d;
    return e;
  endfunction

  initial begin
    int n;
    reset = 1'b1; req = '0; req_rr = '0; we_in = '0;
    addr_in = '0; wdata_in = '0; bus_rdata = '0;
    tick(); tick();
    // Reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bus_addr", 32'(bus_addr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_we_oe", 32'({bus_we, bus_oe}), 0);
    reset = 1'b0;
    tick();

    // Test 1: single CPU read
    addr_in[0*AW +: AW] = 16'h1234;
    bus_rdata = 16'hBEEF;
    req = 4'b0001;
    q.push_back(mk(0, 1'b0, 16'h1234, 16'hBEEF));
    tick();
    chk("t1_gnt", 32'(gnt), 1);
    chk("t1_addr_c1", 32'(bus_addr), 32'h1234);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_we_read", 32'(bus_we), 0);
    tick();
    chk("t1_addr_c2", 32'(bus_addr), 32'h1234);
    chk("t1_no_early_done", 32'(done), 0);
    wait_done(0, n);
    chk("t1_latency", 32'(n), 1);
    req = '0;
    tick();
    chk("t1_done_cleared", 32'(done), 0);
    chk("t1_gnt_cleared", 32'(gnt), 0);
    chk("t1_addr_held", 32'(bus_addr), 32'h1234);
    tick();
    chk("t1_idle", 32'(busy), 0);

    // Test 2: two writers alternate under CPU priority
    we_in = 4'b0110;
    addr_in[1*AW +: AW] = 16'h0010; wdata_in[1*DW +: DW] = 16'hAAAA;
    addr_in[2*AW +: AW] = 16'h0020; wdata_in[2*DW +: DW] = 16'h5555;
    req = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      q.push_back(mk(1, 1'b1, 16'h0010, 16'hAAAA));
      q.push_back(mk(2, 1'b1, 16'h0020, 16'h5555));
    end
    for (int k = 0; k < 4; k++) wait_done(0, n);
    req = '0;
    tick(); tick();

    // Test 3: everyone requesting; priority vs pure round-robin
    reset = 1'b1;
    tick();
    reset = 1'b0;
    we_in = '0;
    bus_rdata = 16'h0F0F;
    for (int i = 0; i < NREQ; i++) addr_in[i*AW +: AW] = 16'h1000 + 16'(i);
    req = 4'b1111; req_rr = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      q.push_back(mk(0, 1'b0, 16'h1000, 16'h0F0F));
      q_rr.push_back(mk(k % NREQ, 1'b0, 16'h1000 + 16'(k % NREQ), 16'h0F0F));
    end
    for (int k = 0; k < 5; k++) wait_done(1, n);
    req = '0; req_rr = '0;

    // Test 4: requester 2 drops req one cycle after its grant
    addr_in[2*AW +: AW] = 16'h0040;
    bus_rdata = 16'h7777;
    req = 4'b0100;
    q.push_back(mk(2, 1'b0, 16'h0040, 16'h7777));
    wait_gnt(n);
    chk("t4_gnt", 32'(gnt), 32'b0100);
    tick();
    req = '0;
    addr_in[2*AW +: AW] = 16'hDEAD;
    bus_rdata = 16'h7777;
    wait_done(0, n);
    tick(); tick(); tick();
    chk("t4_no_gnt", 32'(gnt), 0);
    chk("t4_idle", 32'(busy), 0);

    // Test 5: reset during a write access
    we_in = 4'b0010;
    addr_in[1*AW +: AW] = 16'h0099; wdata_in[1*DW +: DW] = 16'h1357;
    req = 4'b0010;
    wait_gnt(n);
    chk("t5_we", 32'({bus_we, bus_oe}), 32'b11);
    chk("t5_wdata", 32'(bus_wdata), 32'h1357);
    #1 reset = 1'b1;
    #1;
    chk("t5_abort_gnt", 32'(gnt), 0);
    chk("t5_abort_we_oe", 32'({bus_we, bus_oe}), 0);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_done", 32'(done), 0);
    tick();
    chk("t5_still_no_done", 32'(done), 0);
    reset = 1'b0;
    we_in = '0;
    addr_in[0*AW +: AW] = 16'h00A0;
    bus_rdata = 16'h2468;
    req = 4'b0011;
    q.push_back(mk(0, 1'b0, 16'h00A0, 16'h2468));
    wait_done(0, n);
    req = '0;
    tick(); tick();
    chk("sb_drained", 32'(q.size() + q_rr.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
